// File: rtl/l2_fwd_responder.sv
// Private-cache end of the L2 forward handshake: absorbs NoC2 forwards and answers each with a FWDACK on NoC3.
// Response header appears the cycle after the last request flit; NoC3 flits are held until accepted.
module l2_fwd_responder #(
  parameter logic [7:0] MSG_LOAD_FWD     = 8'd16,
  parameter logic [7:0] MSG_STORE_FWD    = 8'd17,
  parameter logic [7:0] MSG_INV_FWD      = 8'd18,
  parameter logic [7:0] MSG_LOAD_FWDACK  = 8'd24,
  parameter logic [7:0] MSG_STORE_FWDACK = 8'd25,
  parameter logic [7:0] MSG_INV_FWDACK   = 8'd26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [13:0]  chipid,
  input  logic [7:0]   coreid_x,
  input  logic [7:0]   coreid_y,
  input  logic         noc2_valid_in,
  input  logic [63:0]  noc2_data_in,
  output logic         noc2_ready_in,
  output logic         noc3_valid_out,
  output logic [63:0]  noc3_data_out,
  input  logic         noc3_ready_out,
  input  logic [127:0] line_data,
  input  logic         line_dirty,
  output logic         err_unknown,
  output logic [15:0]  ack_count
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_SEND, S_DROP} state_t;

  state_t       state_q, state_d;
  logic [7:0]   type_q, type_d, mshr_q, mshr_d, len_q, len_d, cnt_q, cnt_d;
  logic [63:0]  addr_q, addr_d;
  logic [29:0]  home_q, home_d;
  logic [127:0] line_q, line_d;
  logic         with_data_q, with_data_d;
  logic [2:0]   idx_q, idx_d;
  logic         vld_q, vld_d;
  logic [63:0]  dat_q, dat_d;
  logic [15:0]  ack_q, ack_d;
  logic         go_send;

  function automatic logic supported(input logic [7:0] t);
    return (t == MSG_LOAD_FWD) || (t == MSG_STORE_FWD) || (t == MSG_INV_FWD);
  endfunction

  function automatic logic [7:0] ack_type(input logic [7:0] t);
    if (t == MSG_LOAD_FWD)  return MSG_LOAD_FWDACK;
    if (t == MSG_STORE_FWD) return MSG_STORE_FWDACK;
    return MSG_INV_FWDACK;
  endfunction

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    mshr_d      = mshr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    home_d      = home_q;
    line_d      = line_q;
    with_data_d = with_data_q;
    idx_d       = idx_q;
    vld_d       = vld_q;
    dat_d       = dat_q;
    ack_d       = ack_q;
    go_send     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (noc2_valid_in) begin
          type_d = noc2_data_in[21:14];
          mshr_d = noc2_data_in[13:6];
          len_d  = noc2_data_in[29:22];
          cnt_d  = 8'd0;
          addr_d = 64'd0;
          home_d = 30'd0;
          if (len_d != 8'd0)          state_d = S_RECV;
          else if (supported(type_d)) go_send = 1'b1;
          else                        state_d = S_DROP;
        end
      end
      S_RECV: begin
        if (noc2_valid_in) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'd1) addr_d = noc2_data_in;
          if (cnt_d == 8'd2) home_d = noc2_data_in[63:34];
          if (cnt_d == len_q) begin
            if (supported(type_q)) go_send = 1'b1;
            else                   state_d = S_DROP;
          end
        end
      end
      S_DROP: state_d = S_IDLE;
      S_SEND: begin
        if (vld_q && noc3_ready_out) begin
          if (idx_q == (with_data_q ? 3'd4 : 3'd2)) begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
            if (ack_q != 16'hFFFF) ack_d = ack_q + 16'd1;
          end else begin
            idx_d = idx_q + 3'd1;
            case (idx_d)
              3'd1:    dat_d = addr_q;
              3'd2:    dat_d = {chipid, coreid_x, coreid_y, 34'b0};
              3'd3:    dat_d = line_q[127:64];
              3'd4:    dat_d = line_q[63:0];
              default: dat_d = 64'd0;
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Header is built from the next-state fields: the home flit may arrive on this same edge.
    if (go_send) begin
      state_d     = S_SEND;
      line_d      = line_data;
      with_data_d = line_dirty && ((type_d == MSG_LOAD_FWD) || (type_d == MSG_STORE_FWD));
      idx_d       = 3'd0;
      vld_d       = 1'b1;
      dat_d       = {home_d, 4'b0, (with_data_d ? 8'd4 : 8'd2), ack_type(type_d), mshr_d, 6'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      type_q      <= 8'd0;
      mshr_q      <= 8'd0;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      addr_q      <= 64'd0;
      home_q      <= 30'd0;
      line_q      <= 128'd0;
      with_data_q <= 1'b0;
      idx_q       <= 3'd0;
      vld_q       <= 1'b0;
      dat_q       <= 64'd0;
      ack_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      mshr_q      <= mshr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      home_q      <= home_d;
      line_q      <= line_d;
      with_data_q <= with_data_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
    end
  end

  assign noc2_ready_in  = (state_q == S_IDLE) || (state_q == S_RECV);
  assign err_unknown    = (state_q == S_DROP);
  assign noc3_valid_out = vld_q;
  assign noc3_data_out  = dat_q;
  assign ack_count      = ack_q;

endmodule
